// File: rtl/axil_bram_ctrl.sv
// -----------------------------------------------------------------------------
// axil_bram_ctrl
//   AXI4-Lite slave that bridges single-beat reads and writes onto a simple
//   synchronous BRAM port. Only one transaction can be in flight at a time.
//   A write is accepted only when the address and data arrive together. A
//   write wins over a read that is requested in the same cycle.
//
// Ports
//   MCLK, MRESET       sole clock (rising edge); synchronous active-high reset
//   S_AXI_AW*/W*/B*    AXI4-Lite write address, write data, write response
//   S_AXI_AR*/R*       AXI4-Lite read address, read data
//   MEN/MADDR/MDIN/MWE BRAM strobe, byte address (word aligned), write data,
//                      per-byte write enables
//   MDOUT              BRAM read data, valid the cycle after a read strobe
//
// Configuration
//   AXIL_BRAM_CTRL_RANGE_CHECK_EN  when defined, any address with a bit set
//                                  above MADDR_W-1 gets SLVERR and no BRAM
//                                  strobe. When undefined, the upper bits are
//                                  ignored, so such addresses alias.
// -----------------------------------------------------------------------------
module axil_bram_ctrl #(
    parameter  int MEM_DEPTH = 1048576,
    localparam int MADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic               MCLK,
    input  logic               MRESET,
    input  logic [31:0]        S_AXI_AWADDR,
    input  logic               S_AXI_AWVALID,
    output logic               S_AXI_AWREADY,
    input  logic [31:0]        S_AXI_WDATA,
    input  logic [3:0]         S_AXI_WSTRB,
    input  logic               S_AXI_WVALID,
    output logic               S_AXI_WREADY,
    output logic [1:0]         S_AXI_BRESP,
    output logic               S_AXI_BVALID,
    input  logic               S_AXI_BREADY,
    input  logic [31:0]        S_AXI_ARADDR,
    input  logic               S_AXI_ARVALID,
    output logic               S_AXI_ARREADY,
    output logic [31:0]        S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RVALID,
    input  logic               S_AXI_RREADY,
    output logic               MEN,
    output logic [MADDR_W-1:0] MADDR,
    output logic [31:0]        MDIN,
    output logic [3:0]         MWE,
    input  logic [31:0]        MDOUT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RCAP  = 3'd4,
        RRESP = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [MADDR_W-3:0]   word_q, word_d;     // word address; byte offset is dropped
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 oor_q, oor_d;       // captured address is out of range
    logic                 aw_acc_s, ar_acc_s;
    logic [31:0]          unused_addr_s;

    // Byte-offset bits, and in the default build the upper bits, carry no meaning.
    assign unused_addr_s = S_AXI_AWADDR ^ S_AXI_ARADDR;

`ifdef AXIL_BRAM_CTRL_RANGE_CHECK_EN
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        addr_out_of_range = |(addr >> MADDR_W);
    endfunction
`endif

    // Next state, request capture and address-channel accept decisions
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        oor_d    = oor_q;
        aw_acc_s = 1'b0;
        ar_acc_s = 1'b0;
        if (MRESET) begin
            // Reset overrides any handshake offered in the same cycle.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        aw_acc_s = 1'b1;
                        word_d   = S_AXI_AWADDR[MADDR_W-1:2];
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
`ifdef AXIL_BRAM_CTRL_RANGE_CHECK_EN
                        oor_d    = addr_out_of_range(S_AXI_AWADDR);
`else
                        oor_d    = 1'b0;
`endif
                        state_d  = WR;
                    end else if (S_AXI_ARVALID) begin
                        ar_acc_s = 1'b1;
                        word_d   = S_AXI_ARADDR[MADDR_W-1:2];
`ifdef AXIL_BRAM_CTRL_RANGE_CHECK_EN
                        oor_d    = addr_out_of_range(S_AXI_ARADDR);
`else
                        oor_d    = 1'b0;
`endif
                        state_d  = RD;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                WR:    state_d = WRESP;
                WRESP: state_d = S_AXI_BREADY ? IDLE : WRESP;
                RD:    state_d = RCAP;
                RCAP: begin
                    // An out-of-range read never strobed the BRAM, so return zero.
                    rdata_d = oor_q ? 32'h0000_0000 : MDOUT;
                    state_d = RRESP;
                end
                RRESP:   state_d = S_AXI_RREADY ? IDLE : RRESP;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and capture registers
    always_ff @(posedge MCLK) begin
        if (MRESET) begin
            state_q <= IDLE;
            word_q  <= {(MADDR_W-2){1'b0}};
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0000_0000;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    // Output decode: AXI handshakes/responses and the one-cycle BRAM strobe
    always_comb begin
        S_AXI_AWREADY = aw_acc_s;
        S_AXI_WREADY  = aw_acc_s;
        S_AXI_ARREADY = ar_acc_s;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = 2'b00;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RRESP   = 2'b00;
        S_AXI_RDATA   = 32'h0000_0000;
        MEN           = 1'b0;
        MADDR         = {MADDR_W{1'b0}};
        MDIN          = 32'h0000_0000;
        MWE           = 4'h0;
        if (!MRESET) begin
            case (state_q)
                WR: begin
                    MEN   = ~oor_q;
                    MWE   = oor_q ? 4'h0 : wstrb_q;
                    MADDR = {word_q, 2'b00};
                    MDIN  = wdata_q;
                end
                RD: begin
                    MEN   = ~oor_q;
                    MADDR = {word_q, 2'b00};
                end
                WRESP: begin
                    S_AXI_BVALID = 1'b1;
                    S_AXI_BRESP  = oor_q ? 2'b10 : 2'b00;
                end
                RRESP: begin
                    S_AXI_RVALID = 1'b1;
                    S_AXI_RRESP  = oor_q ? 2'b10 : 2'b00;
                    S_AXI_RDATA  = rdata_q;
                end
                default: begin
                end
            endcase
        end else begin
        end
    end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
module tb_axil_bram_ctrl;

    logic        MCLK = 1'b0;
    logic        MRESET;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA, MDIN, MDOUT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [3:0]  S_AXI_WSTRB, MWE;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY, MEN;
    logic [19:0] MADDR;

    always #5 MCLK = ~MCLK;

    axil_bram_ctrl #(.MEM_DEPTH(1048576)) dut (
        .MCLK(MCLK), .MRESET(MRESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .MEN(MEN), .MADDR(MADDR), .MDIN(MDIN), .MWE(MWE), .MDOUT(MDOUT)
    );

    // BRAM model: one-cycle read latency, zero output when not reading
    logic [31:0] bram [0:1023];
    logic [31:0] mdout_q;
    assign MDOUT = mdout_q;
    always @(posedge MCLK) begin
        if (MEN && MWE == 4'h0) mdout_q <= bram[MADDR[11:2]];
        else                    mdout_q <= 32'h0;
        if (MEN)
            for (int b = 0; b < 4; b++)
                if (MWE[b]) bram[MADDR[11:2]][8*b +: 8] <= MDIN[8*b +: 8];
    end

    // Strobe monitor: counts BRAM strobes and records the last one
    int          men_total = 0;
    logic [19:0] men_addr;
    logic [3:0]  men_we;
    logic [31:0] men_din;
    always @(negedge MCLK) begin
        if (MEN) begin
            men_total <= men_total + 1;
            men_addr  <= MADDR;
            men_we    <= MWE;
            men_din   <= MDIN;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q [$];

`ifdef AXIL_BRAM_CTRL_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    function automatic logic any_out();
        any_out = |{S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_BRESP,
                    S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, MEN, MADDR, MDIN, MWE};
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int n;
        @(posedge MCLK); #1;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        n = 0;
        @(negedge MCLK);
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin @(negedge MCLK); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL write_accept_timeout: got no AW/W ready, want ready within 50 cycles"); end
        @(posedge MCLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        lat = 1;
        @(negedge MCLK);
        while (!S_AXI_BVALID && lat < 50) begin @(negedge MCLK); lat++; end
        if (lat >= 50) begin n_cmp++; n_bad++; $display("FAIL bvalid_timeout: got no BVALID, want BVALID within 50 cycles"); end
        resp = S_AXI_BRESP;
        @(posedge MCLK); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, input bit keep_ar,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit stable, output bit early_ar);
        int n;
        @(posedge MCLK); #1;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0;
        @(negedge MCLK);
        while (!S_AXI_ARREADY && n < 50) begin @(negedge MCLK); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL read_accept_timeout: got no ARREADY, want ARREADY within 50 cycles"); end
        @(posedge MCLK); #1;
        if (!keep_ar) S_AXI_ARVALID = 1'b0;
        lat = 1; early_ar = 1'b0;
        @(negedge MCLK);
        while (!S_AXI_RVALID && lat < 50) begin early_ar |= S_AXI_ARREADY; @(negedge MCLK); lat++; end
        if (lat >= 50) begin n_cmp++; n_bad++; $display("FAIL rvalid_timeout: got no RVALID, want RVALID within 50 cycles"); end
        early_ar |= S_AXI_ARREADY;
        data = S_AXI_RDATA; resp = S_AXI_RRESP; stable = 1'b1;
        repeat (hold) begin
            @(negedge MCLK);
            if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp) stable = 1'b0;
            early_ar |= S_AXI_ARREADY;
        end
        @(posedge MCLK); #1;
        S_AXI_RREADY = 1'b1;
        @(negedge MCLK);
        early_ar |= S_AXI_ARREADY;
        @(posedge MCLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge MCLK); #1;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        @(negedge MCLK);
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        n_cmp++; if (any_out() !== 1'b0) begin n_bad++; $display("FAIL reset_outputs: got nonzero=%b want 0", any_out()); end
        @(posedge MCLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge MCLK); #1;
        MRESET = 1'b0;
        @(negedge MCLK);
        n_cmp++; if (any_out() !== 1'b0) begin n_bad++; $display("FAIL idle_outputs: got nonzero=%b want 0", any_out()); end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; int lat, m0; logic [31:0] d; bit st, ea;
        ref_write(32'h10, 32'hDEADBEEF, 4'hF);
        m0 = men_total;
        do_write(32'h0000_0010, 32'hDEADBEEF, 4'hF, resp, lat);
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL wr_bresp: got %b want 00", resp); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (men_total - m0 !== 1) begin n_bad++; $display("FAIL wr_men_cycles: got %0d want 1", men_total - m0); end
        n_cmp++; if ({men_addr, men_we, men_din} !== {20'h00010, 4'hF, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_bram_port: got %h/%h/%h want 00010/f/deadbeef", men_addr, men_we, men_din); end
        exp_q.push_back(ref_mem[32'h10 >> 2]);
        m0 = men_total;
        do_read(32'h10, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", d); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL rd_rresp: got %b want 00", resp); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (men_total - m0 !== 1 || men_addr !== 20'h00010 || men_we !== 4'h0) begin n_bad++; $display("FAIL rd_bram_port: got cnt=%0d addr=%h we=%h want 1/00010/0", men_total - m0, men_addr, men_we); end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; int lat, m0; logic [31:0] d; bit st, ea;
        ref_write(32'h40, 32'h11223344, 4'hF);
        do_write(32'h40, 32'h11223344, 4'hF, resp, lat);
        ref_write(32'h40, 32'hAABBCCDD, 4'h5);
        do_write(32'h40, 32'hAABBCCDD, 4'h5, resp, lat);
        exp_q.push_back(32'h11BB33DD);
        do_read(32'h40, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL strobe_merge: got %h want 11bb33dd", d); end
        m0 = men_total;
        do_write(32'h40, 32'hFFFFFFFF, 4'h0, resp, lat);
        n_cmp++; if (resp !== 2'b00 || lat !== 2) begin n_bad++; $display("FAIL zero_strb_resp: got resp=%b lat=%0d want 00/2", resp, lat); end
        n_cmp++; if (men_total - m0 !== 1 || men_we !== 4'h0) begin n_bad++; $display("FAIL zero_strb_port: got cnt=%0d we=%h want 1/0", men_total - m0, men_we); end
        exp_q.push_back(ref_mem[32'h40 >> 2]);
        do_read(32'h40, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL zero_strb_data: got %h want 11bb33dd", d); end
    endtask

    task automatic test_unaligned();
        logic [1:0] resp; int lat; logic [31:0] d; bit st, ea;
        ref_write(32'h54, 32'hCAFEF00D, 4'hF);
        do_write(32'h57, 32'hCAFEF00D, 4'hF, resp, lat);
        n_cmp++; if (men_addr !== 20'h00054) begin n_bad++; $display("FAIL unaligned_wr_addr: got %h want 00054", men_addr); end
        exp_q.push_back(ref_mem[32'h54 >> 2]);
        do_read(32'h56, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front() || men_addr !== 20'h00054) begin n_bad++; $display("FAIL unaligned_rd: got %h@%h want cafef00d@00054", d, men_addr); end
    endtask

    task automatic test_simultaneous();
        int cyc, b_cyc, ar_cyc, n;
        ref_write(32'h60, 32'h5A5AA5A5, 4'hF);
        exp_q.push_back(ref_mem[32'h60 >> 2]);
        @(posedge MCLK); #1;
        S_AXI_AWADDR = 32'h60; S_AXI_WDATA = 32'h5A5AA5A5; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 32'h60; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge MCLK);
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b110) begin n_bad++; $display("FAIL simul_priority: got %b want 110", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        @(posedge MCLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        cyc = 0; b_cyc = -1; ar_cyc = -1;
        while (ar_cyc < 0 && cyc < 50) begin
            @(negedge MCLK); cyc++;
            if (S_AXI_BVALID && b_cyc < 0) b_cyc = cyc;
            if (S_AXI_ARREADY) ar_cyc = cyc;
        end
        n_cmp++; if (b_cyc !== 2 || ar_cyc !== 3) begin n_bad++; $display("FAIL simul_order: got bvalid@%0d arready@%0d want 2/3", b_cyc, ar_cyc); end
        @(posedge MCLK); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0;
        @(negedge MCLK);
        while (!S_AXI_RVALID && n < 50) begin @(negedge MCLK); n++; end
        n_cmp++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_q.pop_front()) begin n_bad++; $display("FAIL simul_read_data: got v=%b %h want 1 5a5aa5a5", S_AXI_RVALID, S_AXI_RDATA); end
        @(posedge MCLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_rready_stall();
        logic [1:0] resp; int lat, n; logic [31:0] d; bit st, ea;
        ref_write(32'h70, 32'h0BADCAFE, 4'hF);
        do_write(32'h70, 32'h0BADCAFE, 4'hF, resp, lat);
        exp_q.push_back(ref_mem[32'h70 >> 2]);
        exp_q.push_back(ref_mem[32'h70 >> 2]);
        do_read(32'h70, 5, 1'b1, d, resp, lat, st, ea);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL stall_stable: got stable=%b want 1", st); end
        n_cmp++; if (ea !== 1'b0) begin n_bad++; $display("FAIL stall_early_arready: got %b want 0", ea); end
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL stall_data: got %h want 0badcafe", d); end
        @(negedge MCLK);
        n_cmp++; if (S_AXI_ARREADY !== 1'b1) begin n_bad++; $display("FAIL stall_next_arready: got %b want 1", S_AXI_ARREADY); end
        @(posedge MCLK); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        n = 0;
        @(negedge MCLK);
        while (!S_AXI_RVALID && n < 50) begin @(negedge MCLK); n++; end
        n_cmp++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_q.pop_front()) begin n_bad++; $display("FAIL stall_second_read: got v=%b %h want 1 0badcafe", S_AXI_RVALID, S_AXI_RDATA); end
        @(posedge MCLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_range();
        logic [1:0] resp; int lat, m0; logic [31:0] d; bit st, ea;
        ref_write(32'h0, 32'h13579BDF, 4'hF);
        do_write(32'h0, 32'h13579BDF, 4'hF, resp, lat);
        ref_write(32'h4, 32'h24682468, 4'hF);
        do_write(32'h4, 32'h24682468, 4'hF, resp, lat);
        exp_q.push_back(RC ? 32'h0 : ref_mem[0]);
        m0 = men_total;
        do_read(32'h8000_0000, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL range_rd_data: got %h want %h", d, RC ? 32'h0 : 32'h13579BDF); end
        n_cmp++; if (resp !== (RC ? 2'b10 : 2'b00) || lat !== 3) begin n_bad++; $display("FAIL range_rd_resp: got %b lat=%0d want %b lat=3", resp, lat, RC ? 2'b10 : 2'b00); end
        n_cmp++; if (men_total - m0 !== (RC ? 0 : 1)) begin n_bad++; $display("FAIL range_rd_men: got %0d want %0d", men_total - m0, RC ? 0 : 1); end
        if (!RC) ref_write(32'h4, 32'hFFFFFFFF, 4'hF);
        m0 = men_total;
        do_write(32'h8000_0004, 32'hFFFFFFFF, 4'hF, resp, lat);
        n_cmp++; if (resp !== (RC ? 2'b10 : 2'b00) || lat !== 2 || men_total - m0 !== (RC ? 0 : 1)) begin n_bad++; $display("FAIL range_wr: got resp=%b lat=%0d men=%0d want %b/2/%0d", resp, lat, men_total - m0, RC ? 2'b10 : 2'b00, RC ? 0 : 1); end
        exp_q.push_back(ref_mem[1]);
        do_read(32'h4, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL range_wr_effect: got %h want %h", d, ref_mem[1]); end
    endtask

    task automatic test_reset_rcap();
        logic [1:0] resp; int lat, n; logic [31:0] d; bit st, ea, bad;
        ref_write(32'h90, 32'h600DF00D, 4'hF);
        do_write(32'h90, 32'h600DF00D, 4'hF, resp, lat);
        @(posedge MCLK); #1;
        S_AXI_ARADDR = 32'h90; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        n = 0;
        @(negedge MCLK);
        while (!S_AXI_ARREADY && n < 50) begin @(negedge MCLK); n++; end
        @(posedge MCLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge MCLK);
        n_cmp++; if (MEN !== 1'b1) begin n_bad++; $display("FAIL rcap_rd_strobe: got %b want 1", MEN); end
        @(posedge MCLK); #1;
        MRESET = 1'b1;
        @(negedge MCLK);
        n_cmp++; if (any_out() !== 1'b0) begin n_bad++; $display("FAIL rcap_reset_outputs: got nonzero=%b want 0", any_out()); end
        @(posedge MCLK); #1;
        MRESET = 1'b0;
        bad = 1'b0;
        repeat (6) begin @(negedge MCLK); if (S_AXI_RVALID || MEN) bad = 1'b1; end
        n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rcap_abandon: got activity=%b want 0", bad); end
        S_AXI_RREADY = 1'b0;
        exp_q.push_back(ref_mem[32'h90 >> 2]);
        do_read(32'h90, 0, 1'b0, d, resp, lat, st, ea);
        n_cmp++; if (d !== exp_q.pop_front() || resp !== 2'b00 || lat !== 3) begin n_bad++; $display("FAIL rcap_recover: got %h/%b/%0d want 600df00d/00/3", d, resp, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        MRESET = 1'b1;
        S_AXI_AWADDR = 32'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        test_reset();
        test_write_read();
        test_strobes();
        test_unaligned();
        test_simultaneous();
        test_rready_stall();
        test_range();
        test_reset_rcap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_bram_ctrl.md
AXIL_BRAM_CTRL -- requirements
Module: axil_bram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1048576, memory size in bytes; power of two, at least 8.
REQ-002 SHALL have localparam MADDR_W = $clog2(MEM_DEPTH), the BRAM byte-address width.
REQ-003 SHALL have MCLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have MRESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have S_AXI_AWADDR input 32, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1: AXI4-Lite write address channel.
REQ-006 SHALL have S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1: write data channel.
REQ-007 SHALL have S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1: write response channel.
REQ-008 SHALL have S_AXI_ARADDR input 32, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1: read address channel.
REQ-009 SHALL have S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1: read data channel.
REQ-010 SHALL have MEN output 1, MADDR output MADDR_W, MDIN output 32, MWE output 4: downstream BRAM port, byte address, per-byte write enables.
REQ-011 SHALL have MDOUT input 32: BRAM read data, valid exactly one cycle after MEN=1 and zero otherwise.

Function
REQ-012 SHALL implement FSM states IDLE, WR, WRESP, RD, RCAP and RRESP.
REQ-013 In IDLE, when AWVALID and WVALID are both high, SHALL assert AWREADY and WREADY combinationally in that cycle, capture address, data and strobe, and go to WR.
REQ-014 In IDLE, when ARVALID is high and the write pair is not both valid, SHALL assert ARREADY combinationally, capture the address, and go to RD; write has priority on simultaneous requests.
REQ-015 SHALL drive AWREADY, WREADY and ARREADY low outside IDLE; a lone AWVALID or lone WVALID SHALL not be accepted.
REQ-016 In WR, SHALL drive MEN=1, MWE=captured WSTRB, MDIN=captured WDATA and MADDR={captured addr[MADDR_W-1:2],2'b00} for exactly one cycle, then go to WRESP.
REQ-017 In WRESP, SHALL hold BVALID=1 with BRESP stable until BREADY is high, then return to IDLE in the following cycle.
REQ-018 In RD, SHALL drive MEN=1, MWE=0 and the word-aligned MADDR for exactly one cycle, then go to RCAP.
REQ-019 In RCAP, SHALL register MDOUT into RDATA, then go to RRESP.
REQ-020 In RRESP, SHALL hold RVALID=1 with RDATA and RRESP stable until RREADY is high, then return to IDLE.
REQ-021 Write latency SHALL be: accept cycle, then WR, then BVALID in the next cycle. Read latency SHALL be: accept cycle, then RD, then RCAP, then RVALID.
REQ-022 WSTRB=0 SHALL still perform the WR cycle with MWE=0 and return OKAY (2'b00).
REQ-023 Outside WR and RD, SHALL drive MEN=0, MWE=0, MADDR=0 and MDIN=0.
REQ-024 AWADDR and ARADDR bits [1:0] SHALL be ignored.
REQ-025 At most one transaction SHALL be outstanding; no request SHALL be accepted while BVALID or RVALID is high.

Reset
REQ-026 While MRESET is high, SHALL set the FSM to IDLE and drive all outputs 0 (BRESP=RRESP=2'b00, RDATA=0).
REQ-027 Reset asserted in any state SHALL abandon the pending transaction with no response issued and no BRAM strobe in the following cycle.
REQ-028 MRESET high SHALL take precedence over a handshake in the same cycle; no ready signal SHALL assert.

Configuration
REQ-029 Macro AXIL_BRAM_CTRL_RANGE_CHECK_EN SHALL control range checking.
REQ-030 With the macro defined, an address with any bit in [31:MADDR_W] set SHALL be out of range: MEN stays 0 in WR/RD, BRESP/RRESP=2'b10 (SLVERR), RDATA=0, and timing SHALL be unchanged.
REQ-031 Without the macro, address bits [31:MADDR_W] SHALL be ignored (aliasing), and the response SHALL always be OKAY.

Verification
REQ-032 Write 0x00000010 with data 0xDEADBEEF, WSTRB=0xF, then read 0x10 -> MADDR=0x10, MWE=0xF for one cycle, BRESP=00, RDATA=0xDEADBEEF, RRESP=00.
REQ-033 AWVALID, WVALID and ARVALID all raised in the same cycle -> write accepted first, ARREADY asserts only after the B handshake, and the read returns the new data.
REQ-034 Write 0x11223344 (WSTRB=0xF), then write 0xAABBCCDD with WSTRB=0x5, then read -> RDATA=0x11BB33DD.
REQ-035 RREADY held low for 5 cycles -> RVALID and RDATA stable for all 5 cycles; next ARREADY no earlier than the cycle after the handshake.
REQ-036 With the macro defined, read 0x80000000 -> MEN never high, RRESP=10, RDATA=0. Without the macro -> MEN high, RRESP=00, aliases address 0.
REQ-037 MRESET pulsed during RCAP -> RVALID never asserts, all outputs 0, and a subsequent read completes normally.
